// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver (and transmitter).
//   state_t      receiver FSM states
//   D_WIDTH_DEF  default data bits per frame
//   LINE_IDLE    idle level of the serial line
//   even_parity  XOR of up to 32 data bits (zero-extend narrower words)
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   localparam int   D_WIDTH_DEF = 8;
   localparam logic LINE_IDLE   = 1'b1;

   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: clk_cnt owner for serial bit timing.
//   clk   clock
//   rst   synchronous active-high reset
//   run   counting enabled; counter held at 0 while low
//   half  select half-bit terminal count (start-bit centre) instead of full bit
//   tick  sample strobe; counter restarts from 0 on the following cycle
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic half,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] clk_cnt;

   assign tick = run && (clk_cnt == (half ? HALF : FULL));

   always_ff @(posedge clk) begin
      if (rst)
         clk_cnt <= '0;
      else if (!run || tick)
         clk_cnt <= '0;
      else
         clk_cnt <= clk_cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receiver. Frame = start(0), D_WIDTH data LSB first,
// even parity, stop(1). Completed bytes land in a one-entry valid/ready
// register together with parity/frame status.
//   clk, rst    clock, synchronous active-high reset
//   rxd         serial line, idle high
//   rx_data     received byte (qualified by rx_valid)
//   rx_valid    output register holds a byte
//   rx_ready    consumer accepts when rx_valid && rx_ready
//   parity_err  parity mismatch for held byte
//   frame_err   stop bit sampled 0 for held byte
//   overrun     one-cycle pulse when a completed frame is dropped
//   busy        receiver not in IDLE
// Optional: define UART_RX_SYNC_EN to pass rxd through a two-flop
// synchronizer (adds 2 cycles of latency).
module uart_rx
   import uart_pkg::*;
#(
   parameter int D_WIDTH      = D_WIDTH_DEF,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rxd,
   output logic [D_WIDTH-1:0] rx_data,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic               parity_err,
   output logic               frame_err,
   output logic               overrun,
   output logic               busy
);

   localparam int BW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(D_WIDTH - 1);

   logic               rxd_s;
   state_t             state, state_nxt;
   logic [BW-1:0]      bit_cnt;
   logic [D_WIDTH-1:0] shreg;
   logic               perr;
   logic               tick;
   logic               complete;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clk) begin
      if (rst)
         sync <= {2{LINE_IDLE}};
      else
         sync <= {sync[0], rxd};
   end
   assign rxd_s = sync[1];
`else
   assign rxd_s = rxd;
`endif

   // START uses the half-bit count to land on the start-bit centre; every
   // later sample is a full bit after the previous one.
   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .run  ((state == START) || (state == DATA) || (state == PARITY) || (state == STOP)),
      .half (state == START),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      case (state)
         IDLE:
            // With one clock per bit the detecting cycle is already the
            // start-bit sample, so skip START entirely.
            if (rxd_s == 1'b0)
               state_nxt = (CLKS_PER_BIT == 1) ? DATA : START;
         START:
            if (tick)
               state_nxt = rxd_s ? IDLE : DATA;
         DATA:
            if (tick && bit_cnt == LAST)
               state_nxt = PARITY;
         PARITY:
            if (tick)
               state_nxt = STOP;
         STOP:
            if (tick) begin
               complete  = 1'b1;
               state_nxt = rxd_s ? IDLE : WAIT_IDLE;
            end
         WAIT_IDLE:
            // Hold off on a break / stuck-low line until it goes idle.
            if (rxd_s == LINE_IDLE)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
      end else begin
         if (state != DATA)
            bit_cnt <= '0;
         else if (tick) begin
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
            shreg   <= {rxd_s, shreg[D_WIDTH-1:1]};
         end
         if (state == PARITY && tick)
            perr <= rxd_s ^ even_parity(32'(shreg));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (complete && (!rx_valid || rx_ready)) begin
            rx_data    <= shreg;
            parity_err <= perr;
            frame_err  <= ~rxd_s;
            rx_valid   <= 1'b1;
         end else begin
            if (complete)
               overrun <= 1'b1;
            if (rx_valid && rx_ready)
               rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Two instances share clk/rst:
// u_dut1 at one clock per bit and u_dut16 at 16 clocks per bit.
// Inputs change 1 time unit after posedge; outputs are read there too.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       rxd1 = 1'b1, rdy1 = 1'b1;
   logic [7:0] data1;
   logic       vld1, perr1, ferr1, ovr1, busy1;

   logic       rxd16 = 1'b1, rdy16 = 1'b1;
   logic [7:0] data16;
   logic       vld16, perr16, ferr16, ovr16, busy16;

   int checks = 0;
   int errors = 0;

   // monitor state for u_dut1 / u_dut16
   int         cyc, cap_cnt, cap_idx, ovr_cnt, ovr_idx;
   logic [7:0] cap_data;
   logic       cap_perr, cap_ferr;

   always #5 clk = ~clk;

   uart_rx #(.D_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .rxd(rxd1), .rx_data(data1), .rx_valid(vld1),
      .rx_ready(rdy1), .parity_err(perr1), .frame_err(ferr1),
      .overrun(ovr1), .busy(busy1)
   );

   uart_rx #(.D_WIDTH(8), .CLKS_PER_BIT(16)) u_dut16 (
      .clk(clk), .rst(rst), .rxd(rxd16), .rx_data(data16), .rx_valid(vld16),
      .rx_ready(rdy16), .parity_err(perr16), .frame_err(ferr16),
      .overrun(ovr16), .busy(busy16)
   );

   // bit 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop
   function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   task automatic clr_mon();
      cyc = 0; cap_cnt = 0; cap_idx = -1; ovr_cnt = 0; ovr_idx = -1;
      cap_data = 8'h00; cap_perr = 1'b0; cap_ferr = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic b);
      rxd1 = b;
      tick();
      if (vld1) begin
         if (cap_cnt == 0) cap_idx = cyc;
         cap_cnt++;
         cap_data = data1; cap_perr = perr1; cap_ferr = ferr1;
      end
      if (ovr1) begin
         ovr_cnt++;
         ovr_idx = cyc;
      end
      cyc++;
   endtask

   task automatic send1(input logic [10:0] f);
      for (int i = 0; i < 11; i++) drive1(f[i]);
   endtask

   task automatic drive16(input logic b, input int n);
      rxd16 = b;
      for (int i = 0; i < n; i++) begin
         tick();
         if (vld16) begin
            cap_cnt++;
            cap_data = data16; cap_perr = perr16; cap_ferr = ferr16;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({data1, vld1, perr1, ferr1, ovr1, busy1} !== 13'h0) begin
         errors++;
         $display("FAIL reset_dut1 got data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
                  data1, vld1, perr1, ferr1, ovr1, busy1);
      end
      checks++;
      if ({data16, vld16, perr16, ferr16, ovr16, busy16} !== 13'h0) begin
         errors++;
         $display("FAIL reset_dut16 got data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
                  data16, vld16, perr16, ferr16, ovr16, busy16);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_loopback();
      clr_mon();
      rdy1 = 1'b1;
      send1(frame(8'hA5, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) drive1(1'b1);
      checks++;
      if (cap_data !== 8'hA5 || cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin
         errors++;
         $display("FAIL loopback_data got %h pe=%b fe=%b expected a5 pe=0 fe=0", cap_data, cap_perr, cap_ferr);
      end
      checks++;
      if (cap_cnt !== 1 || cap_idx !== 10 + LAT) begin
         errors++;
         $display("FAIL loopback_latency got cnt=%0d idx=%0d expected cnt=1 idx=%0d", cap_cnt, cap_idx, 10 + LAT);
      end
   endtask

   task automatic test_parity();
      clr_mon();
      send1(frame(8'h01, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) drive1(1'b1);
      checks++;
      if (cap_cnt !== 1 || cap_data !== 8'h01 || cap_perr !== 1'b1 || cap_ferr !== 1'b0) begin
         errors++;
         $display("FAIL parity_err got cnt=%0d data=%h pe=%b fe=%b expected 1 01 pe=1 fe=0",
                  cap_cnt, cap_data, cap_perr, cap_ferr);
      end
   endtask

   task automatic test_frame_err();
      clr_mon();
      send1(frame(8'h3C, 1'b0, 1'b0));
      drive1(1'b0); drive1(1'b0);
      checks++;
      if (cap_cnt !== 1 || cap_data !== 8'h3C || cap_perr !== 1'b0 || cap_ferr !== 1'b1) begin
         errors++;
         $display("FAIL frame_err got cnt=%0d data=%h pe=%b fe=%b expected 1 3c pe=0 fe=1",
                  cap_cnt, cap_data, cap_perr, cap_ferr);
      end
      clr_mon();
      for (int i = 0; i < 3; i++) drive1(1'b0);
      checks++;
      if (busy1 !== 1'b1 || cap_cnt !== 0) begin
         errors++;
         $display("FAIL break_hold got busy=%b frames=%0d expected busy=1 frames=0", busy1, cap_cnt);
      end
      for (int i = 0; i < 1 + LAT; i++) drive1(1'b1);
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL break_release got busy=%b expected 0", busy1);
      end
      for (int i = 0; i < 3; i++) drive1(1'b1);
      checks++;
      if (cap_cnt !== 0) begin
         errors++;
         $display("FAIL break_no_frame got frames=%0d expected 0", cap_cnt);
      end
   endtask

   task automatic test_back_to_back();
      clr_mon();
      rdy1 = 1'b0;
      send1(frame(8'h11, 1'b0, 1'b1));
      drive1(1'b1);
      send1(frame(8'h22, 1'b0, 1'b1));
      for (int i = 0; i < 4; i++) drive1(1'b1);
      checks++;
      if (vld1 !== 1'b1 || data1 !== 8'h11 || perr1 !== 1'b0 || ferr1 !== 1'b0) begin
         errors++;
         $display("FAIL hold_first got v=%b data=%h pe=%b fe=%b expected v=1 11 pe=0 fe=0",
                  vld1, data1, perr1, ferr1);
      end
      checks++;
      if (ovr_cnt !== 1 || ovr_idx !== 22 + LAT) begin
         errors++;
         $display("FAIL overrun_pulse got cnt=%0d idx=%0d expected cnt=1 idx=%0d", ovr_cnt, ovr_idx, 22 + LAT);
      end
      rdy1 = 1'b1;
      tick();
      checks++;
      if (vld1 !== 1'b0) begin
         errors++;
         $display("FAIL ready_drain got v=%b expected 0", vld1);
      end
   endtask

   task automatic test_false_start();
      logic [10:0] f;
      clr_mon();
      drive16(1'b0, 3);
      checks++;
      if (busy16 !== 1'b1) begin
         errors++;
         $display("FAIL glitch_detect got busy=%b expected 1", busy16);
      end
      drive16(1'b1, 30);
      checks++;
      if (busy16 !== 1'b0 || cap_cnt !== 0) begin
         errors++;
         $display("FAIL false_start got busy=%b frames=%0d expected busy=0 frames=0", busy16, cap_cnt);
      end
      f = frame(8'h5A, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) drive16(f[i], 16);
      drive16(1'b1, 20);
      checks++;
      if (cap_cnt !== 1 || cap_data !== 8'h5A || cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin
         errors++;
         $display("FAIL cpb16_frame got cnt=%0d data=%h pe=%b fe=%b expected 1 5a pe=0 fe=0",
                  cap_cnt, cap_data, cap_perr, cap_ferr);
      end
   endtask

   task automatic test_mid_reset();
      logic [10:0] f;
      clr_mon();
      rdy1 = 1'b0;
      send1(frame(8'h33, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++) drive1(1'b1);
      checks++;
      if (vld1 !== 1'b1 || data1 !== 8'h33) begin
         errors++;
         $display("FAIL held_before_rst got v=%b data=%h expected v=1 33", vld1, data1);
      end
      f = frame(8'hFF, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drive1(f[i]);   // start + data bits 0..3
      rxd1 = f[5];
      rst  = 1'b1;
      tick();
      checks++;
      if ({data1, vld1, perr1, ferr1, ovr1, busy1} !== 13'h0) begin
         errors++;
         $display("FAIL mid_reset got data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
                  data1, vld1, perr1, ferr1, ovr1, busy1);
      end
      rst  = 1'b0;
      rdy1 = 1'b1;
      clr_mon();
      for (int i = 0; i < 4; i++) drive1(1'b1);
      checks++;
      if (cap_cnt !== 0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got frames=%0d busy=%b expected 0 0", cap_cnt, busy1);
      end
      send1(frame(8'h80, 1'b1, 1'b1));
      for (int i = 0; i < 4; i++) drive1(1'b1);
      checks++;
      if (cap_cnt !== 1 || cap_data !== 8'h80 || cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_frame got cnt=%0d data=%h pe=%b fe=%b expected 1 80 pe=0 fe=0",
                  cap_cnt, cap_data, cap_perr, cap_ferr);
      end
   endtask

   initial begin
      clr_mon();
      test_reset();
      test_loopback();
      test_parity();
      test_frame_err();
      test_back_to_back();
      test_false_start();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
